// File: rtl/urukul_spi_master.sv
// SPI master for the Urukul EEM: encoded chip select, MSB-first shift of up to 32 bits,
// programmable SCK half-period and an optional IO_UPDATE strobe after CS release.
module urukul_spi_master #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned LEN_W = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [2:0]       cs_sel,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] div,
    input  logic [31:0]      wdata,
    input  logic             upd,
    output logic             ready,
    output logic             done,
    output logic [31:0]      rdata,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic [2:0]       cs,
    output logic             io_update
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StUpdate
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      shift_q, shift_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             upd_q, upd_d;
    logic             upd_phase_q, upd_phase_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [2:0]       cs_q, cs_d;
    logic             io_q, io_d;
    logic             done_q, done_d;
    logic             phase_end;

    assign phase_end = (cnt_q == '0);
    // The done cycle still reads as busy so a start on that cycle is dropped.
    assign ready     = (state_q == StIdle) && !done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        upd_d       = upd_q;
        upd_phase_d = upd_phase_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        io_d        = io_q;
        done_d      = 1'b0;

        if (state_q != StIdle && !phase_end) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (start && ready) begin
                    div_d   = div;
                    cnt_d   = div;
                    bit_d   = 5'(len);
                    wdata_d = wdata;
                    upd_d   = upd;
                    cs_d    = cs_sel;
                    mosi_d  = wdata[5'(len)];
                    shift_d = '0;
                    state_d = StSetup;
                end
            end
            StSetup, StLow: begin
                if (phase_end) begin
                    sck_d   = 1'b1;
                    shift_d = {shift_q[30:0], miso};
                    cnt_d   = div_q;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (phase_end) begin
                    sck_d = 1'b0;
                    cnt_d = div_q;
                    if (bit_q != 5'd0) begin
                        bit_d   = bit_q - 5'd1;
                        mosi_d  = wdata_q[bit_q - 5'd1];
                        state_d = StLow;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (phase_end) begin
                    cs_d   = 3'd0;
                    mosi_d = 1'b0;
                    cnt_d  = div_q;
                    if (upd_q) begin
                        upd_phase_d = 1'b0;
                        state_d     = StUpdate;
                    end else begin
                        done_d  = 1'b1;
                        rdata_d = shift_q;
                        state_d = StIdle;
                    end
                end
            end
            StUpdate: begin
                // First phase is a gap after CS release, second phase drives the strobe.
                if (phase_end) begin
                    cnt_d = div_q;
                    if (!upd_phase_q) begin
                        upd_phase_d = 1'b1;
                        io_d        = 1'b1;
                    end else begin
                        io_d    = 1'b0;
                        done_d  = 1'b1;
                        rdata_d = shift_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            upd_q       <= 1'b0;
            upd_phase_q <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 3'd0;
            io_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            upd_q       <= upd_d;
            upd_phase_q <= upd_phase_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
            io_q        <= io_d;
            done_q      <= done_d;
        end
    end

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign cs        = cs_q;
    assign io_update = io_q;

endmodule

// File: tb/tb_urukul_spi_master.sv
// Scoreboard bench for urukul_spi_master: a CPLD-side model drives miso, a monitor measures
// each transaction (edges, period, busy time, IO_UPDATE) and checks it on done.
module tb_urukul_spi_master;

    localparam int DIV_W = 8;
    localparam int LEN_W = 6;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       cs_sel = 3'd0;
    logic [LEN_W-1:0] len = '0;
    logic [DIV_W-1:0] div = '0;
    logic [31:0]      wdata = '0;
    logic             upd = 1'b0;
    logic             miso;
    logic             ready, done, sck, mosi, io_update;
    logic [31:0]      rdata;
    logic [2:0]       cs;

    typedef struct {
        logic [31:0] rdata;
        int          edges;
        logic [31:0] mosi_word;
        logic [2:0]  cs;
        int          period;
        int          busy;
        int          io_cnt;
        int          io_gap;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] miso_word = '0;
    int          miso_len = 0;
    logic        miso_load = 1'b0;
    int          miso_idx;

    urukul_spi_master #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .cs_sel    (cs_sel),
        .len       (len),
        .div       (div),
        .wdata     (wdata),
        .upd       (upd),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .cs        (cs),
        .io_update (io_update)
    );

    always #5 sys_clk = ~sys_clk;

    // CPLD model: first bit presented at load, next bit after every SCK falling edge.
    always @(negedge sck or posedge miso_load) begin
        if (miso_load) miso_idx = miso_len;
        else if (miso_idx > 0) miso_idx--;
        miso = miso_word[miso_idx];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input int e, input logic [31:0] m,
                                input logic [2:0] c, input int p, input int b, input int ic,
                                input int ig);
        exp_t x;
        x.rdata = r; x.edges = e; x.mosi_word = m; x.cs = c;
        x.period = p; x.busy = b; x.io_cnt = ic; x.io_gap = ig;
        return x;
    endfunction

    task automatic monitor();
        int cyc = 0, edges = 0, busy = 0, io_cnt = 0, io_gap = -1, cs_fall = -1;
        int last_rise = 0, per_min = 1000000, per_max = 0, cs_bad = 0, p;
        logic [31:0] macc = '0;
        logic [2:0]  cs_first = '0, pcs = '0;
        logic        psck = 1'b0, pio = 1'b0, chk_ready = 1'b0;
        exp_t        e;
        forever begin
            @(posedge sys_clk); #1;
            if (!sys_rst_n) begin
                edges = 0; busy = 0; io_cnt = 0; io_gap = -1; cs_fall = -1; cs_bad = 0;
                per_min = 1000000; per_max = 0; macc = '0; psck = 1'b0; pio = 1'b0;
                pcs = '0; chk_ready = 1'b0;
                continue;
            end
            cyc++;
            if (chk_ready) begin
                chk("ready after done", 32'(ready), 32'd1);
                chk_ready = 1'b0;
            end
            if (!ready) busy++;
            if (sck && !psck) begin
                edges++;
                macc = {macc[30:0], mosi};
                if (edges == 1) cs_first = cs;
                else begin
                    if (cs != cs_first) cs_bad++;
                    p = cyc - last_rise;
                    if (p < per_min) per_min = p;
                    if (p > per_max) per_max = p;
                end
                last_rise = cyc;
            end
            if (pcs != 3'd0 && cs == 3'd0) cs_fall = cyc;
            if (io_update && !pio) io_gap = cyc - cs_fall;
            if (io_update) io_cnt++;
            psck = sck; pio = io_update; pcs = cs;
            if (done) begin
                chk("done has pending transaction", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("sck rising edges", 32'(edges), 32'(e.edges));
                    chk("mosi word", macc, e.mosi_word);
                    chk("cs at sck rise", 32'(cs_first), 32'(e.cs));
                    chk("cs stable", 32'(cs_bad), 32'd0);
                    if (e.period > 0) begin
                        chk("sck period min", 32'(per_min), 32'(e.period));
                        chk("sck period max", 32'(per_max), 32'(e.period));
                    end
                    chk("busy cycles", 32'(busy), 32'(e.busy));
                    chk("io_update cycles", 32'(io_cnt), 32'(e.io_cnt));
                    if (e.io_gap >= 0) chk("io_update gap", 32'(io_gap), 32'(e.io_gap));
                end
                edges = 0; busy = 0; io_cnt = 0; io_gap = -1; cs_fall = -1; cs_bad = 0;
                per_min = 1000000; per_max = 0; macc = '0;
                chk_ready = 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [2:0] c, input int l, input int d, input logic [31:0] w,
                         input logic u, input logic [31:0] mw, input logic push, input exp_t e);
        for (int k = 0; k < 200 && !ready; k++) begin
            @(posedge sys_clk); #1;
        end
        chk("ready before start", 32'(ready), 32'd1);
        if (push) exp_q.push_back(e);
        miso_word = mw; miso_len = l; miso_load = 1'b1;
        cs_sel = c; len = LEN_W'(l); div = DIV_W'(d); wdata = w; upd = u; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; miso_load = 1'b0;
        // Scramble inputs so the in-flight transaction must rely on its latched copy.
        cs_sel = ~c; len = '1; div = DIV_W'(d + 3); wdata = ~w; upd = ~u;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge sys_clk); #1;
            if (done) break;
        end
        chk("done within budget", 32'(done), 32'd1);
    endtask

    initial begin
        exp_t none;
        int   rises;
        logic ps;
        none = mk(0, 0, 0, 0, 0, 0, 0, -1);
        fork
            monitor();
        join_none

        #3;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset sck", 32'(sck), 32'd0);
        chk("reset mosi", 32'(mosi), 32'd0);
        chk("reset cs", 32'(cs), 32'd0);
        chk("reset io_update", 32'(io_update), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        chk("post-reset ready", 32'(ready), 32'd1);
        chk("post-reset sck", 32'(sck), 32'd0);

        // CFG write
        issue(3'd1, 23, 3, 32'h000A5F0F, 1'b0, 32'h00ABCDEF, 1'b1,
              mk(32'h00ABCDEF, 24, 32'h000A5F0F, 3'd1, 8, 197, 0, -1));
        wait_done(400);
        // Full-width readback at sys_clk/2
        issue(3'd7, 31, 0, 32'h12345678, 1'b0, 32'hC3A51E7B, 1'b1,
              mk(32'hC3A51E7B, 32, 32'h12345678, 3'd7, 2, 66, 0, -1));
        wait_done(200);
        // Single bit
        issue(3'd3, 0, 2, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1,
              mk(32'h00000001, 1, 32'h00000001, 3'd3, 0, 10, 0, -1));
        wait_done(100);
        // IO_UPDATE
        issue(3'd4, 7, 1, 32'h000000A5, 1'b1, 32'h0000003C, 1'b1,
              mk(32'h0000003C, 8, 32'h000000A5, 3'd4, 4, 39, 2, 2));
        wait_done(200);
        // Busy protection: start mid-transfer and on the done cycle
        issue(3'd2, 15, 1, 32'h0000BEEF, 1'b0, 32'h00001234, 1'b1,
              mk(32'h00001234, 16, 32'h0000BEEF, 3'd2, 4, 67, 0, -1));
        repeat (10) begin
            @(posedge sys_clk); #1;
        end
        start = 1'b1; cs_sel = 3'd6; len = LEN_W'(2); wdata = 32'h0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        wait_done(200);
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge sys_clk); #1;
        end
        chk("no requeued transfer cs", 32'(cs), 32'd0);
        chk("no requeued transfer ready", 32'(ready), 32'd1);

        // Reset abort after 5 SCK rising edges
        issue(3'd5, 31, 2, 32'hFFFF0000, 1'b0, 32'h0, 1'b0, none);
        rises = 0;
        ps = sck;
        for (int k = 0; k < 400 && rises < 5; k++) begin
            @(posedge sys_clk); #1;
            if (sck && !ps) rises++;
            ps = sck;
        end
        chk("rises before abort", 32'(rises), 32'd5);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("abort sck", 32'(sck), 32'd0);
        chk("abort cs", 32'(cs), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort done", 32'(done), 32'd0);
        @(posedge sys_clk); #1;
        chk("abort rdata cleared", rdata, 32'd0);
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(posedge sys_clk); #1;
        end
        chk("after abort ready", 32'(ready), 32'd1);

        // cs_sel=0 still clocks, cs stays 0
        issue(3'd0, 3, 0, 32'h0000000A, 1'b0, 32'h00000005, 1'b1,
              mk(32'h00000005, 4, 32'h0000000A, 3'd0, 2, 10, 0, -1));
        wait_done(100);

        repeat (5) begin
            @(posedge sys_clk); #1;
        end
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
